// File: rtl/homomorphic_multiply_sequencer.sv
// Host-side initiator for homomorphic_multiply: buffers two ciphertext operands, streams them in
// the core's row/select schedule and captures the reduced product coefficients for host readback.
`timescale 1ns/1ps
module homomorphic_multiply_sequencer #(
    parameter int unsigned PLAINTEXT_MODULUS  = 64,
    parameter int unsigned PLAINTEXT_WIDTH    = 6,
    parameter int unsigned CIPHERTEXT_MODULUS = 1024,
    parameter int unsigned CIPHERTEXT_WIDTH   = 21,
    parameter int unsigned DIMENSION          = 3,
    parameter int unsigned BIG_N              = 30
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               load_en,
    input  logic                               load_sel,
    input  logic [DIMENSION:0]                 load_addr,
    input  logic signed [CIPHERTEXT_WIDTH-1:0] load_data,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    input  logic [DIMENSION:0]                 rd_addr,
    output logic signed [CIPHERTEXT_WIDTH-1:0] rd_data,
    output logic signed [CIPHERTEXT_WIDTH-1:0] ciphertext_entry,
    output logic [DIMENSION:0]                 row,
    output logic                               ciphertext_select,
    output logic                               en,
    input  logic signed [CIPHERTEXT_WIDTH-1:0] result_partial
);

    localparam int unsigned CW     = CIPHERTEXT_WIDTH;
    localparam int unsigned RowW   = DIMENSION + 1;
    localparam int unsigned NumOp  = DIMENSION + 1;
    localparam int unsigned NumRes = 2 * DIMENSION + 1;
    localparam int unsigned OpAw   = $clog2(NumOp);
    localparam int unsigned ResAw  = $clog2(NumRes);

    localparam logic [RowW-1:0] RowLast       = RowW'(DIMENSION);
    localparam logic [RowW-1:0] RowDrainFirst = RowW'(DIMENSION + 1);
    localparam logic [RowW-1:0] RowDrainLast  = RowW'(2 * DIMENSION);
    localparam logic signed [CW:0] ModS       = (CW + 1)'(CIPHERTEXT_MODULUS);

    // Pass-through parameters belong to the core; only their sanity is checked here.
    if (DIMENSION < 1 || CIPHERTEXT_MODULUS < 2 || PLAINTEXT_MODULUS < 1 || PLAINTEXT_WIDTH < 1 ||
        BIG_N < 1 || CIPHERTEXT_MODULUS >= (1 << (CIPHERTEXT_WIDTH - 1))) begin : g_bad_params
        $error("homomorphic_multiply_sequencer: invalid parameter set");
    end

    typedef enum logic [2:0] {StIdle, StSendA, StSendB, StDrain, StFlush} state_e;

    state_e                 state_q, state_d;
    logic [RowW-1:0]        row_q, row_d;
    logic                   sel_q, sel_d;
    logic                   en_q, en_d;
    logic signed [CW-1:0]   entry_q, entry_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic signed [CW-1:0]   op_a_q [NumOp];
    logic signed [CW-1:0]   op_a_d [NumOp];
    logic signed [CW-1:0]   op_b_q [NumOp];
    logic signed [CW-1:0]   op_b_d [NumOp];
    logic signed [CW-1:0]   res_q  [NumRes];
    logic signed [CW-1:0]   res_d  [NumRes];
    logic                   cap_vld_q, cap_vld_d;
    logic [RowW-1:0]        cap_idx_q, cap_idx_d;
    logic signed [CW-1:0]   rd_data_q, rd_data_d;
    logic signed [CW:0]     part_ext;
    logic signed [CW:0]     part_rem;

    // Operand buffers; the next-state copy lets a load coinciding with start feed row 0 directly.
    always_comb begin
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        if (load_en && state_q == StIdle && load_addr <= RowLast) begin
            if (load_sel) begin
                op_b_d[load_addr[OpAw-1:0]] = load_data;
            end else begin
                op_a_d[load_addr[OpAw-1:0]] = load_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSendA;
                    row_d   = '0;
                end
            end
            StSendA: begin
                if (row_q == RowLast) begin
                    state_d = StSendB;
                    row_d   = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            StSendB: begin
                if (row_q == RowLast) begin
                    state_d = StDrain;
                    row_d   = RowDrainFirst;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            StDrain: begin
                if (row_q == RowDrainLast) begin
                    state_d = StFlush;
                    row_d   = '0;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            StFlush: begin
                state_d = StIdle;
                row_d   = '0;
            end
            default: begin
                state_d = StIdle;
                row_d   = '0;
            end
        endcase
    end

    // Core-side pins are decoded from the next state so the registered outputs line up with state_q.
    always_comb begin
        en_d    = (state_d == StSendA) || (state_d == StSendB) || (state_d == StDrain);
        sel_d   = (state_d == StSendB);
        entry_d = '0;
        if (state_d == StSendA) begin
            entry_d = op_a_d[row_d[OpAw-1:0]];
        end else if (state_d == StSendB) begin
            entry_d = op_b_d[row_d[OpAw-1:0]];
        end
        busy_d = (state_d != StIdle);
        done_d = (state_q == StFlush);
    end

    // Coefficient k arrives the cycle after row k, so capture uses last cycle's state and row.
    always_comb begin
        cap_vld_d = (state_q == StSendB) || (state_q == StDrain);
        cap_idx_d = row_q;
        part_ext  = {result_partial[CW-1], result_partial};
        part_rem  = part_ext % ModS;
        if (part_rem < 0) begin
            part_rem = part_rem + ModS;
        end
        res_d = res_q;
        if (cap_vld_q && cap_idx_q <= RowDrainLast) begin
            res_d[cap_idx_q[ResAw-1:0]] = part_rem[CW-1:0];
        end
        rd_data_d = '0;
        if (rd_addr <= RowDrainLast) begin
            rd_data_d = res_q[rd_addr[ResAw-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            row_q     <= '0;
            sel_q     <= 1'b0;
            en_q      <= 1'b0;
            entry_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            op_a_q    <= '{default: '0};
            op_b_q    <= '{default: '0};
            res_q     <= '{default: '0};
            cap_vld_q <= 1'b0;
            cap_idx_q <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            sel_q     <= sel_d;
            en_q      <= en_d;
            entry_q   <= entry_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            res_q     <= res_d;
            cap_vld_q <= cap_vld_d;
            cap_idx_q <= cap_idx_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign row               = row_q;
    assign ciphertext_select = sel_q;
    assign en                = en_q;
    assign ciphertext_entry  = entry_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign rd_data           = rd_data_q;

endmodule

// File: tb/tb_homomorphic_multiply_sequencer.sv
// Self-checking bench: a behavioural core model answers the row stream, and a convolution model
// predicts the reduced results, pin schedule and busy/done timing.
`timescale 1ns/1ps
module tb_homomorphic_multiply_sequencer;

    localparam int D    = 3;
    localparam int CW   = 21;
    localparam int MOD  = 1024;
    localparam int NOP  = D + 1;
    localparam int NRES = 2 * D + 1;
    localparam int AW   = D + 1;
    localparam int BUSY = 3 * D + 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 load_en, load_sel, start;
    logic [AW-1:0]        load_addr, rd_addr, row;
    logic signed [CW-1:0] load_data, rd_data, ciphertext_entry, result_partial;
    logic                 busy, done, ciphertext_select, en;

    int checks   = 0;
    int failures = 0;
    int model_a [NOP];
    int model_b [NOP];
    int exp_r   [NRES];
    logic signed [CW-1:0] core_a [NOP];
    logic signed [CW-1:0] core_b [NOP];

    homomorphic_multiply_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .load_en           (load_en),
        .load_sel          (load_sel),
        .load_addr         (load_addr),
        .load_data         (load_data),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .ciphertext_entry  (ciphertext_entry),
        .row               (row),
        .ciphertext_select (ciphertext_select),
        .en                (en),
        .result_partial    (result_partial)
    );

    always #5 clk = ~clk;

    function automatic logic signed [CW-1:0] core_coef(input int k);
        int s = 0;
        for (int i = 0; i <= D; i++) begin
            if (k - i >= 0 && k - i <= D) s += int'(core_a[i]) * int'(core_b[k - i]);
        end
        return CW'(s);
    endfunction

    // Core model: coefficient k appears the cycle after row k in the B/drain phases; garbage otherwise.
    always @(posedge clk) begin
        if (en && !ciphertext_select) begin
            if (row == 0) begin
                for (int i = 0; i < NOP; i++) begin
                    core_a[i] = '0;
                    core_b[i] = '0;
                end
            end
            if (int'(row) <= D) core_a[int'(row)] = ciphertext_entry;
        end
        if (en && ciphertext_select && int'(row) <= D) core_b[int'(row)] = ciphertext_entry;
        if (en && (ciphertext_select || int'(row) > D)) result_partial <= core_coef(int'(row));
        else result_partial <= CW'($urandom);
    end

    function automatic void compute_expected();
        for (int k = 0; k < NRES; k++) begin
            int s = 0;
            int r;
            for (int i = 0; i <= D; i++) begin
                if (k - i >= 0 && k - i <= D) s += model_a[i] * model_b[k - i];
            end
            r = s % MOD;
            if (r < 0) r += MOD;
            exp_r[k] = r;
        end
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; load_en = 0; load_sel = 0; load_addr = '0; load_data = '0;
        start = 0; rd_addr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NOP; i++) begin
            model_a[i] = 0;
            model_b[i] = 0;
        end
    endtask

    task automatic load_word(input bit sel, input int addr, input int data);
        load_en = 1; load_sel = sel; load_addr = AW'(addr); load_data = CW'(data);
        @(posedge clk); #1;
        load_en = 0;
        if (addr <= D) begin
            if (sel) model_b[addr] = data;
            else model_a[addr] = data;
        end
    endtask

    task automatic load_ops(input int a[NOP], input int b[NOP]);
        for (int i = 0; i < NOP; i++) load_word(1'b0, i, a[i]);
        for (int i = 0; i < NOP; i++) load_word(1'b1, i, b[i]);
    endtask

    task automatic read_all();
        for (int k = 0; k <= NRES + 1; k++) begin
            int a = (k == NRES + 1) ? 15 : k;
            logic signed [CW-1:0] e;
            rd_addr = AW'(a);
            @(posedge clk); #1;
            e = (a < NRES) ? CW'(exp_r[a]) : '0;
            checks++;
            if (rd_data !== e) begin
                failures++;
                $display("FAIL rd_data[%0d] got=%0d exp=%0d", a, rd_data, e);
            end
        end
    endtask

    // Drives start now (caller is away from the clock edge) and checks every cycle until done.
    task automatic run_op(input bit abuse, input bit combo, input int combo_data, input bit reads);
        start = 1;
        if (combo) begin
            load_en = 1; load_sel = 0; load_addr = '0; load_data = CW'(combo_data);
            model_a[0] = combo_data;
        end
        @(posedge clk); #1;
        start = 0; load_en = 0;
        compute_expected();
        for (int c = 0; c < BUSY; c++) begin
            logic [AW-1:0] er;
            logic es, ee;
            logic signed [CW-1:0] ent;
            @(negedge clk);
            er = '0; es = 0; ee = 0; ent = '0;
            if (c <= D) begin
                er = AW'(c); ee = 1; ent = CW'(model_a[c]);
            end else if (c <= 2 * D + 1) begin
                er = AW'(c - D - 1); es = 1; ee = 1; ent = CW'(model_b[c - D - 1]);
            end else if (c <= 3 * D + 1) begin
                er = AW'(c - D - 1); ee = 1;
            end
            checks += 6;
            if (busy !== 1'b1) begin failures++; $display("FAIL busy c%0d got=%b exp=1", c, busy); end
            if (done !== 1'b0) begin failures++; $display("FAIL done c%0d got=%b exp=0", c, done); end
            if (en !== ee) begin failures++; $display("FAIL en c%0d got=%b exp=%b", c, en, ee); end
            if (row !== er) begin failures++; $display("FAIL row c%0d got=%0d exp=%0d", c, row, er); end
            if (ciphertext_select !== es) begin
                failures++; $display("FAIL select c%0d got=%b exp=%b", c, ciphertext_select, es);
            end
            if (ciphertext_entry !== ent) begin
                failures++; $display("FAIL entry c%0d got=%0d exp=%0d", c, ciphertext_entry, ent);
            end
            if (abuse && (c == 2 || c == 5 || c == 9)) begin
                start = 1; load_en = 1; load_sel = 1'($urandom);
                load_addr = AW'($urandom_range(0, D)); load_data = CW'($urandom_range(1, 500));
            end else begin
                start = 0; load_en = 0;
            end
        end
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_end got=%b exp=0", busy); end
        if (done !== 1'b1) begin failures++; $display("FAIL done_pulse got=%b exp=1", done); end
        if (reads) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin failures++; $display("FAIL done_width got=%b exp=0", done); end
            read_all();
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({busy, done, en, ciphertext_select} !== 4'b0 || row !== '0 || ciphertext_entry !== '0 ||
            rd_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b%b%b%b row=%0d ent=%0d rd=%0d exp=all0", busy, done,
                     en, ciphertext_select, row, ciphertext_entry, rd_data);
        end
        compute_expected();
        read_all();
    endtask

    task automatic test_all_ones();
        load_ops('{1, 1, 1, 1}, '{1, 1, 1, 1});
        run_op(0, 0, 0, 1);
    endtask

    task automatic test_negative();
        load_ops('{-1, 0, 0, 0}, '{5, 0, 0, 0});
        load_word(1'b0, 5, 777);
        load_word(1'b1, 9, 321);
        run_op(0, 0, 0, 1);
    endtask

    task automatic test_wrap();
        load_ops('{1000, 0, 0, 0}, '{2, 0, 0, 0});
        run_op(0, 0, 0, 1);
        load_ops('{3, 2, 0, 0}, '{1, 4, 0, 0});
        run_op(0, 0, 0, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            int a [NOP];
            int b [NOP];
            for (int i = 0; i < NOP; i++) begin
                a[i] = $urandom_range(0, 600) - 300;
                b[i] = $urandom_range(0, 600) - 300;
            end
            load_ops(a, b);
            run_op(0, 0, 0, 1);
        end
    endtask

    task automatic test_abuse_and_combo();
        load_ops('{7, -3, 11, 2}, '{-9, 4, 1, 6});
        run_op(1, 0, 0, 1);
        run_op(0, 1, -250, 1);
    endtask

    task automatic test_back_to_back();
        load_ops('{2, 5, -4, 1}, '{3, 0, 8, -7});
        run_op(0, 0, 0, 0);
        run_op(0, 1, 123, 1);
    endtask

    task automatic test_reset_mid_run();
        int n = 0;
        bit done_seen = 0;
        load_ops('{1, 1, 1, 1}, '{1, 1, 1, 1});
        start = 1;
        @(posedge clk); #1;
        start = 0;
        while (ciphertext_select !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin failures++; $display("FAIL reach_send_b got=timeout exp=select"); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, en, ciphertext_select} !== 4'b0 || row !== '0 || ciphertext_entry !== '0 ||
            rd_data !== '0) begin
            failures++;
            $display("FAIL midrun_reset_outputs got=%b%b%b%b row=%0d ent=%0d rd=%0d exp=all0", busy,
                     done, en, ciphertext_select, row, ciphertext_entry, rd_data);
        end
        repeat (2) begin
            @(negedge clk);
            if (done) done_seen = 1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < NOP; i++) begin
            model_a[i] = 0;
            model_b[i] = 0;
        end
        repeat (15) begin
            @(negedge clk);
            if (done || busy) done_seen = 1;
        end
        checks++;
        if (done_seen) begin failures++; $display("FAIL midrun_no_done got=activity exp=idle"); end
        compute_expected();
        read_all();
        load_ops('{1, 1, 1, 1}, '{1, 1, 1, 1});
        run_op(0, 0, 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_all_ones();
        test_negative();
        test_wrap();
        test_random();
        test_abuse_and_combo();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/homomorphic_multiply_sequencer.md
# homomorphic_multiply_sequencer

Host-side driver for `homomorphic_multiply`, the initiator end of its row-streaming interface. It holds two ciphertext operand vectors of DIMENSION+1 entries, each loaded by the host. On `start` it streams them into the core in the core's row/select schedule and captures the 2·DIMENSION+1 streamed product coefficients. Each coefficient is reduced into [0, CIPHERTEXT_MODULUS-1] and stored in a result buffer that the host reads by address.

## Interface
- PLAINTEXT_MODULUS, 64, passed through to the core; unused internally
- PLAINTEXT_WIDTH, 6, passed through; unused internally
- CIPHERTEXT_MODULUS, 1024, reduction modulus for captured coefficients
- CIPHERTEXT_WIDTH, 21, signed entry/coefficient width
- DIMENSION, 3, highest coefficient index; operand length DIMENSION+1
- BIG_N, 30, passed through; unused internally

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_en  in  1  operand write strobe
- load_sel  in  1  0 = operand A, 1 = operand B
- load_addr  in  DIMENSION+1  operand index, 0..DIMENSION
- load_data  in  CIPHERTEXT_WIDTH  signed operand entry
- start  in  1  begin a multiply
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- rd_addr  in  DIMENSION+1  result index, 0..2·DIMENSION
- rd_data  out  CIPHERTEXT_WIDTH  reduced coefficient, registered
- ciphertext_entry  out  CIPHERTEXT_WIDTH  to core
- row  out  DIMENSION+1  to core
- ciphertext_select  out  1  to core
- en  out  1  to core
- result_partial  in  CIPHERTEXT_WIDTH  from core, signed

## Operation
- Core contract:
  - In phases SEND_B and DRAIN, the core shows coefficient k on `result_partial` in the cycle after `row`=k was presented.
  - Presenting select=0, row=0 starts a new product.
- States: IDLE → SEND_A → SEND_B → DRAIN → FLUSH → IDLE.
  - IDLE: `start`=1 at a clock edge moves to SEND_A and sets `busy`=1.
  - SEND_A: DIMENSION+1 cycles, row=i, select=0, entry=A[i], en=1.
  - SEND_B: DIMENSION+1 cycles, row=j, select=1, entry=B[j], en=1.
  - DRAIN: DIMENSION cycles, row=DIMENSION+1..2·DIMENSION, select=0, entry=0, en=1.
  - FLUSH: 1 cycle, en=0, row=0, select=0, entry=0. The final coefficient is captured here.
- Capture:
  - A capture flag and index are the previous cycle's (state ∈ {SEND_B, DRAIN}, row), registered.
  - When the flag is set, `result_partial` is written to R[index].
- Reduction: R[k] = result_partial mod CIPHERTEXT_MODULUS, always non-negative. Negative inputs add the modulus after the signed remainder; -5 → 1019.
- Loads:
  - Accepted only in IDLE; ignored while busy.
  - load_addr > DIMENSION is ignored.
  - Simultaneous `load_en` and `start` in IDLE: the load is written and `start` is taken in the same cycle, so the new value is used.
- `start` while busy is ignored; no queueing.
- Reads:
  - rd_data = R[rd_addr] one cycle after rd_addr.
  - rd_addr > 2·DIMENSION returns 0.
  - During busy, a read returns the buffer's current, partially updated contents.

## Timing
- Reset values:
  - `busy`, `done`, `en`, `row`, `ciphertext_select`, `ciphertext_entry` and `rd_data` are 0; state is IDLE.
  - Operand and result buffers are cleared to 0.
- Busy time:
  - `busy` is high for 3·DIMENSION+3 cycles, starting the cycle after `start` is sampled.
  - For DIMENSION=3 that is 12 cycles.
- Completion:
  - `done` pulses for one cycle immediately after FLUSH, in the same cycle `busy` falls.
  - R is complete when `done` pulses.
- Back-to-back: `start` may be sampled in the `done` cycle, giving one idle cycle between operations.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. No `done` pulse; buffers are cleared.
- All core-side outputs are registered.

## Test plan
- All-ones, D=3: A=B=[1,1,1,1], start → R[0..6]=1,2,3,4,3,2,1. Busy 12 cycles, one `done` pulse.
- Negative coefficient: A=[-1,0,0,0], B=[5,0,0,0] → R[0]=1019, R[1..6]=0.
- Modular wrap: A=[1000,0,0,0], B=[2,0,0,0] → R[0]=976. Also A=[3,2,0,0], B=[1,4,0,0] → R[0..2]=3,14,8.
- Schedule check: monitor core pins on every cycle.
  - row/select sequence must be 0..3/0, 0..3/1, 4..6/0.
  - `en` low outside SEND_A..DRAIN.
- Protocol abuse:
  - Pulse `start` and `load_en` mid-operation → no effect on R or timing.
  - rd_addr=7 → rd_data=0.
- Reset mid-run: deassert rst_n during SEND_B → outputs and buffers 0, no `done`. Re-load all-ones and restart → the first scenario's results.
